// File: rtl/rv32i_types.sv
// Shared RV32I types plus the branch-resolve queue entry and FSM state.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_word pc;
    logic      pred_taken;
    rv32i_word pred_target;
  } br_pred_entry_t;

  typedef enum logic {
    BR_RUN     = 1'b0,
    BR_RECOVER = 1'b1
  } br_res_state_t;

  function automatic rv32i_word br_fallthrough(input rv32i_word pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/br_resolve_if.sv
// Pipeline-facing signals of the branch resolver: IF push, EX resolve, recovery outputs.
interface br_resolve_if;
  import rv32i_types::*;

  logic        stall;
  logic        if_push;
  rv32i_word   if_pc;
  logic        if_pred_taken;
  rv32i_word   if_pred_target;
  rv32i_opcode ex_ctrl_opcode;
  rv32i_word   ex_pc;
  logic        branch_taken;
  rv32i_word   alu_out;
  logic        flush;
  rv32i_word   redirect_pc;
  logic        full;
  logic        sync_err;
  rv32i_word   br_count;
  rv32i_word   mispred_count;

  modport master (
    output stall, if_push, if_pc, if_pred_taken, if_pred_target,
           ex_ctrl_opcode, ex_pc, branch_taken, alu_out,
    input  flush, redirect_pc, full, sync_err, br_count, mispred_count
  );

  modport slave (
    input  stall, if_push, if_pc, if_pred_taken, if_pred_target,
           ex_ctrl_opcode, ex_pc, branch_taken, alu_out,
    output flush, redirect_pc, full, sync_err, br_count, mispred_count
  );
endinterface

// File: rtl/br_resolve_pred_queue.sv
// Circular FIFO of in-flight branch predictions; head is visible combinationally
// so EX can compare and pop in the same cycle.
module pred_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic           clear,
  input  br_pred_entry_t wr_entry,
  output logic           full,
  output logic           empty,
  output br_pred_entry_t head
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]  head_ptr_reg;
  logic [PW-1:0]  tail_ptr_reg;
  logic [PW:0]    count_reg;
  br_pred_entry_t mem [DEPTH];
  logic           do_push;
  logic           do_pop;

  // A push into a full queue is only accepted when a pop frees the head slot.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (do_push && tail_ptr_reg == PW'(gi)) begin
          mem[gi] <= wr_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (do_push) tail_ptr_reg <= tail_ptr_reg + 1'b1;
      if (do_pop)  head_ptr_reg <= head_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[head_ptr_reg];
  assign full  = (count_reg == (PW+1)'(DEPTH));
  assign empty = (count_reg == '0);
endmodule

// File: rtl/br_resolve.sv
// Branch resolver: matches EX-stage branch outcomes against queued IF predictions,
// raises a one-cycle flush with the correct PC on mispredict, and keeps statistics.
module br_resolve
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  br_resolve_if.slave  bus
);
  br_res_state_t  state_reg, state_next;
  br_pred_entry_t head;
  br_pred_entry_t wr_entry;
  logic           q_full, q_empty, q_push, q_pop;
  logic           in_run, resolve, push_req, pc_mismatch, mispred, push_err;
  rv32i_word      redirect_reg, br_count_reg, mispred_count_reg;
  logic           sync_err_reg;

  assign wr_entry = '{pc: bus.if_pc, pred_taken: bus.if_pred_taken,
                      pred_target: bus.if_pred_target};

  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .pop      (q_pop),
    .clear    (mispred),
    .wr_entry (wr_entry),
    .full     (q_full),
    .empty    (q_empty),
    .head     (head)
  );

  always_comb begin
    in_run      = (state_reg == BR_RUN);
    resolve     = in_run & ~bus.stall & (bus.ex_ctrl_opcode == op_br);
    push_req    = in_run & ~bus.stall & bus.if_push;
    pc_mismatch = resolve & ~q_empty & (head.pc != bus.ex_pc);
    mispred     = resolve & (q_empty
                             | (head.pc != bus.ex_pc)
                             | (head.pred_taken != bus.branch_taken)
                             | (bus.branch_taken & (head.pred_target != bus.alu_out)));
    // Any resolve in RUN either pops the head or clears the queue, so a push
    // alongside it never overflows.
    push_err    = push_req & q_full & ~resolve;
    q_push      = push_req & ~mispred;
    q_pop       = resolve & ~mispred;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= BR_RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BR_RUN:     if (mispred) state_next = BR_RECOVER;
      BR_RECOVER: state_next = BR_RUN;
      default:    state_next = BR_RUN;
    endcase
  end

  always_comb begin
    bus.flush = 1'b0;
    if (state_reg == BR_RECOVER) bus.flush = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_reg      <= '0;
      sync_err_reg      <= 1'b0;
      br_count_reg      <= '0;
      mispred_count_reg <= '0;
    end else begin
      if (mispred) begin
        redirect_reg <= bus.branch_taken ? bus.alu_out : br_fallthrough(bus.ex_pc);
      end
      if ((resolve & q_empty) | pc_mismatch | push_err) sync_err_reg <= 1'b1;
      if (resolve) br_count_reg      <= br_count_reg + 32'd1;
      if (mispred) mispred_count_reg <= mispred_count_reg + 32'd1;
    end
  end

  assign bus.redirect_pc   = redirect_reg;
  assign bus.full          = q_full;
  assign bus.sync_err      = sync_err_reg;
  assign bus.br_count      = br_count_reg;
  assign bus.mispred_count = mispred_count_reg;
endmodule
